// File: rtl/dff_pipe.sv
// WIDTH-bit, DEPTH-stage registered pipeline with per-stage valid bits,
// valid/ready backpressure, bubble collapsing, synchronous flush and occupancy.
module dff_pipe #(
    parameter int unsigned          WIDTH     = 8,
    parameter int unsigned          DEPTH     = 4,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0,
    localparam int unsigned         CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;

    // A stage may move when it is empty or the stage below it moves;
    // this is what lets bubbles collapse behind a stalled output.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = !v[DEPTH-1] | out_ready;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            adv[i] = !v[i] | adv[i+1];
        end
    end

    assign in_ready  = adv[0] & !clr;
    assign out_valid = v[DEPTH-1] & !clr;
    assign out_data  = d[DEPTH-1];

    always_comb begin
        count = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            count = count + CW'(v[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                d[i] <= RESET_VAL;
            end
        end else if (clr) begin
            v <= '0;
        end else begin
            // Stage 0 takes the producer; each later stage takes its upstream neighbour.
            if (adv[0]) begin
                v[0] <= in_valid;
                if (in_valid) begin
                    d[0] <= in_data;
                end
            end
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (adv[i]) begin
                    v[i] <= v[i-1];
                    if (v[i-1]) begin
                        d[i] <= d[i-1];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dff_pipe.sv
// Directed, table-driven bench for dff_pipe (DEPTH=4 main instance plus a
// DEPTH=1 instance with a non-zero RESET_VAL).
module tb_dff_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] count;

    logic       s_in_valid;
    logic       s_in_ready;
    logic [7:0] s_in_data;
    logic       s_out_valid;
    logic       s_out_ready;
    logic [7:0] s_out_data;
    logic       s_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut (
        .clk(clk), .reset(reset), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    dff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h3C)) dut1 (
        .clk(clk), .reset(reset), .clr(1'b0),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .count(s_count)
    );

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       cl;
        logic       ov;
        logic [7:0] od;
        logic [2:0] cnt;
        logic       ir;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic iv, logic [7:0] id, logic ordy, logic cl,
                                logic ov, logic [7:0] od, logic [2:0] cnt, logic ir);
        vec_t r;
        r.iv = iv; r.id = id; r.ordy = ordy; r.cl = cl;
        r.ov = ov; r.od = od; r.cnt = cnt; r.ir = ir;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic ov, input logic [7:0] od,
                             input logic [2:0] cnt, input logic ir);
        n_vec++;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".out_data"},  32'(out_data),  32'(od));
        chk({tag, ".count"},     32'(count),     32'(cnt));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; clr = 1'b0;
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_data = 8'h00; s_out_ready = 1'b0;

        // Held in reset with traffic offered: nothing may be captured.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_state($sformatf("reset%0d", c), 1'b0, 8'h00, 3'd0, 1'b1);
            chk("reset.d1_out_data", 32'(s_out_data), 32'h3C);
            chk("reset.d1_count", 32'(s_count), 32'h0);
        end
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        chk_state("release", 1'b0, 8'h00, 3'd0, 1'b1);
        @(posedge clk); #1;

        // Streaming 01..10 at full rate, then drain.
        for (int k = 0; k <= 20; k++) begin
            vec_t r;
            r.iv   = (k < 16);
            r.id   = (k < 16) ? 8'(k + 1) : 8'h00;
            r.ordy = 1'b1;
            r.cl   = 1'b0;
            r.ov   = (k >= 4 && k <= 19);
            r.od   = (k < 4) ? 8'h00 : (k <= 19) ? 8'(k - 3) : 8'h10;
            r.cnt  = (k < 4) ? 3'(k) : (k <= 16) ? 3'd4 : 3'(20 - k);
            r.ir   = 1'b1;
            vecs.push_back(r);
        end
        // Backpressure and bubble collapse.
        vecs.push_back(mk(1, 8'h11, 0, 0,  0, 8'h10, 3'd0, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0,  0, 8'h10, 3'd1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0,  0, 8'h10, 3'd1, 1));
        vecs.push_back(mk(1, 8'h22, 0, 0,  0, 8'h10, 3'd1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0,  1, 8'h11, 3'd2, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0,  1, 8'h11, 3'd2, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0,  1, 8'h11, 3'd2, 1));
        vecs.push_back(mk(1, 8'h33, 0, 0,  1, 8'h11, 3'd2, 1));
        vecs.push_back(mk(1, 8'h44, 0, 0,  1, 8'h11, 3'd3, 1));
        vecs.push_back(mk(1, 8'h55, 0, 0,  1, 8'h11, 3'd4, 0));
        vecs.push_back(mk(1, 8'h55, 1, 0,  1, 8'h11, 3'd4, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0,  1, 8'h22, 3'd4, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0,  1, 8'h33, 3'd3, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0,  1, 8'h44, 3'd2, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0,  1, 8'h55, 3'd1, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0,  0, 8'h55, 3'd0, 1));
        // Fill, then full with simultaneous in/out transfers.
        vecs.push_back(mk(1, 8'h61, 0, 0,  0, 8'h55, 3'd0, 1));
        vecs.push_back(mk(1, 8'h62, 0, 0,  0, 8'h55, 3'd1, 1));
        vecs.push_back(mk(1, 8'h63, 0, 0,  0, 8'h55, 3'd2, 1));
        vecs.push_back(mk(1, 8'h64, 0, 0,  0, 8'h55, 3'd3, 1));
        vecs.push_back(mk(1, 8'h65, 1, 0,  1, 8'h61, 3'd4, 1));
        vecs.push_back(mk(1, 8'h66, 1, 0,  1, 8'h62, 3'd4, 1));
        vecs.push_back(mk(1, 8'h67, 1, 0,  1, 8'h63, 3'd4, 1));
        vecs.push_back(mk(1, 8'h68, 1, 0,  1, 8'h64, 3'd4, 1));
        vecs.push_back(mk(1, 8'h69, 1, 0,  1, 8'h65, 3'd4, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0,  1, 8'h66, 3'd4, 1));
        // Flush at count=3 with traffic offered both sides.
        vecs.push_back(mk(1, 8'h77, 1, 1,  0, 8'h67, 3'd3, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0,  0, 8'h67, 3'd0, 1));
        // Refill to full ahead of the asynchronous reset.
        vecs.push_back(mk(1, 8'h81, 0, 0,  0, 8'h67, 3'd0, 1));
        vecs.push_back(mk(1, 8'h82, 0, 0,  0, 8'h67, 3'd1, 1));
        vecs.push_back(mk(1, 8'h83, 0, 0,  0, 8'h67, 3'd2, 1));
        vecs.push_back(mk(1, 8'h84, 0, 0,  0, 8'h67, 3'd3, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0,  1, 8'h81, 3'd4, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].id;
            out_ready = vecs[i].ordy;
            clr       = vecs[i].cl;
            @(negedge clk);
            chk_state($sformatf("vec%0d", i), vecs[i].ov, vecs[i].od, vecs[i].cnt, vecs[i].ir);
            @(posedge clk); #1;
        end

        // DEPTH=1: single register, in_ready follows out_ready once full.
        s_in_valid = 1'b1; s_in_data = 8'h5A; s_out_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        chk("d1.in_ready_empty", 32'(s_in_ready), 32'h1);
        chk("d1.out_valid_empty", 32'(s_out_valid), 32'h0);
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        chk("d1.out_valid_full", 32'(s_out_valid), 32'h1);
        chk("d1.out_data_full", 32'(s_out_data), 32'h5A);
        chk("d1.count_full", 32'(s_count), 32'h1);
        chk("d1.in_ready_stall", 32'(s_in_ready), 32'h0);
        s_out_ready = 1'b1;
        #1;
        chk("d1.in_ready_drain", 32'(s_in_ready), 32'h1);
        @(posedge clk); #1;
        s_out_ready = 1'b0;

        // Asynchronous reset between edges while the main pipe is full.
        in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
        @(negedge clk);
        chk_state("prereset", 1'b1, 8'h81, 3'd4, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk_state("async_reset", 1'b0, 8'h00, 3'd0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_state("post_reset", 1'b0, 8'h00, 3'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
